// File: rtl/slc3_datapath_p.sv
// SLC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address adder, shared bus, wait-state MDR reads.
// Optional macro DP_BUS_CHECK_EN adds a sticky bus_err output flagging multiple simultaneous bus drivers.
module slc3_datapath_p #(
  parameter int              DW          = 16,
  parameter logic [DW-1:0]   PC_RST      = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_reg,
  input  logic          ld_ben,
  input  logic          ld_cc,
  input  logic          ld_ir,
  input  logic          ld_pc,
  input  logic          ld_mar,
  input  logic          ld_mdr,
  input  logic          gate_pc,
  input  logic          gate_mdr,
  input  logic          gate_alu,
  input  logic          gate_marmux,
  input  logic          drmux,
  input  logic          sr1mux,
  input  logic          addr1mux,
  input  logic          mio_en,
  input  logic [1:0]    addr2mux,
  input  logic [1:0]    aluk,
  input  logic [1:0]    pcmux,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          mem_req,
  output logic          mdr_busy,
  output logic          mem_err,
  output logic          ben,
  output logic [2:0]    nzp,
`ifdef DP_BUS_CHECK_EN
  output logic          bus_err,
`endif
  output logic [DW-1:0] ir,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] mar,
  output logic [DW-1:0] mdr
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [DW-1:0] regs [8];
  logic [2:0]    dr_sel;
  logic [2:0]    sr1_sel;
  logic [DW-1:0] sr1_val;
  logic [DW-1:0] sr2_val;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] addr1;
  logic [DW-1:0] addr2;
  logic [DW-1:0] adder_sum;
  logic [DW-1:0] bus;
  logic [DW-1:0] pc_next;
  logic [2:0]    nzp_next;

  mem_state_t state;
  mem_state_t state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic       mdr_take_bus;
  logic       mdr_take_mem;
  logic       mdr_take_ones;

  assign dr_sel  = drmux  ? 3'b111   : ir[11:9];
  assign sr1_sel = sr1mux ? ir[8:6]  : ir[11:9];
  assign sr1_val = regs[sr1_sel];
  assign sr2_val = ir[5] ? {{(DW-5){ir[4]}}, ir[4:0]} : regs[ir[2:0]];

  always_comb begin
    alu_out = '0;
    case (aluk)
      2'b00:   alu_out = sr1_val + sr2_val;
      2'b01:   alu_out = sr1_val & sr2_val;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  assign addr1 = addr1mux ? pc : sr1_val;

  always_comb begin
    addr2 = '0;
    case (addr2mux)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = {{(DW-6){ir[5]}},  ir[5:0]};
      2'b10:   addr2 = {{(DW-9){ir[8]}},  ir[8:0]};
      default: addr2 = {{(DW-11){ir[10]}}, ir[10:0]};
    endcase
  end

  assign adder_sum = addr1 + addr2;

  // Fixed-priority bus so a control glitch with two gates never creates contention.
  always_comb begin
    bus = '0;
    if (gate_mdr)         bus = mdr;
    else if (gate_alu)    bus = alu_out;
    else if (gate_pc)     bus = pc;
    else if (gate_marmux) bus = adder_sum;
  end

  always_comb begin
    pc_next = pc;
    case (pcmux)
      2'b00:   pc_next = pc + 1'b1;
      2'b01:   pc_next = bus;
      2'b10:   pc_next = adder_sum;
      default: pc_next = pc;
    endcase
  end

  assign nzp_next = {bus[DW-1], bus == '0, !bus[DW-1] && (bus != '0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (ld_reg) begin
      regs[dr_sel] <= bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= PC_RST;
      ir  <= '0;
      mar <= '0;
    end else begin
      if (ld_pc)  pc  <= pc_next;
      if (ld_ir)  ir  <= bus;
      if (ld_mar) mar <= bus;
    end
  end

  // ben reads the pre-edge nzp, so a same-edge ld_cc cannot affect it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzp <= 3'b010;
      ben <= 1'b0;
    end else begin
      if (ld_cc)  nzp <= nzp_next;
      if (ld_ben) ben <= |(ir[11:9] & nzp);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mdr_take_bus  = 1'b0;
    mdr_take_mem  = 1'b0;
    mdr_take_ones = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_mdr && mio_en) begin
          state_next    = S_WAIT;
          wait_cnt_next = '0;
        end else if (ld_mdr) begin
          mdr_take_bus = 1'b1;
        end
      end
      default: begin
        if (mem_valid) begin
          mdr_take_mem = 1'b1;
          state_next   = S_IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          mdr_take_ones = 1'b1;
          state_next    = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr     <= '0;
      mem_err <= 1'b0;
    end else begin
      if (mdr_take_mem)       mdr <= mem_rdata;
      else if (mdr_take_ones) mdr <= '1;
      else if (mdr_take_bus)  mdr <= bus;
      if (mdr_take_ones) mem_err <= 1'b1;
    end
  end

  assign mem_req  = (state == S_WAIT);
  assign mdr_busy = (state == S_WAIT);

`ifdef DP_BUS_CHECK_EN
  logic [2:0] gate_cnt;
  assign gate_cnt = {2'b00, gate_pc} + {2'b00, gate_mdr} + {2'b00, gate_alu} + {2'b00, gate_marmux};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              bus_err <= 1'b0;
    else if (gate_cnt >= 3'd2) bus_err <= 1'b1;
  end
`endif

endmodule
